// File: rtl/counter_run_ctrl.sv
// Run controller for the binary up-counter datapath: sequences count 0..limit
// with start/pause/abort, one-shot or auto-reload, and busy/done/tc status.
module counter_run_ctrl #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             reload_mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q,  mode_d;
    logic             tc_q,    tc_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        tc_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (start && !abort) begin
                    limit_d = limit;
                    mode_d  = reload_mode;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (pause) begin
                    // Terminal action is deferred until the run resumes.
                    state_d = S_HOLD;
                end else if (count_q == limit_q) begin
                    tc_d = 1'b1;
                    if (mode_q) begin
                        count_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end

            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                count_d = '0;
            end

            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        count = count_q;
        busy  = (state_q == S_RUN) || (state_q == S_HOLD);
        done  = (state_q == S_DONE);
        tc    = tc_q;
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench for counter_run_ctrl: each driven cycle pushes the expected
// outputs, which are popped and compared one time unit after the next edge.
module tb_counter_run_ctrl;

    localparam int unsigned W = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic         reload_mode = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         tc;

    typedef struct {
        int unsigned cnt;
        int unsigned bsy;
        int unsigned dn;
        int unsigned t;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    counter_run_ctrl #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .reload_mode (reload_mode),
        .limit       (limit),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int unsigned c, input int unsigned b,
                              input int unsigned d, input int unsigned t);
        exp_t e;
        e.cnt = c; e.bsy = b; e.dn = d; e.t = t; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Advance one edge, then compare DUT outputs with the oldest expectation.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        check_eq("sb_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq({e.tag, ".count"}, count, e.cnt);
            check_eq({e.tag, ".busy"},  busy,  e.bsy);
            check_eq({e.tag, ".done"},  done,  e.dn);
            check_eq({e.tag, ".tc"},    tc,    e.t);
        end
    endtask

    task automatic launch(input int unsigned lim, input logic mode, input string tag);
        limit = W'(lim);
        reload_mode = mode;
        start = 1'b1;
        expect_out(tag, 0, 1, 0, 0);
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst.count", count, 0);
        check_eq("rst.busy",  busy,  0);
        check_eq("rst.done",  done,  0);
        check_eq("rst.tc",    tc,    0);
        reset = 1'b1;
        expect_out("idle0", 0, 0, 0, 0);
        tick();

        // One-shot, limit=5
        launch(5, 1'b0, "os5.start");
        for (int unsigned i = 1; i <= 5; i++) begin
            expect_out("os5.run", i, 1, 0, 0);
            tick();
        end
        expect_out("os5.done", 5, 0, 1, 1);
        tick();
        expect_out("os5.idle", 0, 0, 0, 0);
        tick();

        // One-shot limit=5 with start re-pulsed at count 3 and limit/mode changed
        launch(5, 1'b0, "ign.start");
        for (int unsigned i = 1; i <= 3; i++) begin
            expect_out("ign.run", i, 1, 0, 0);
            tick();
        end
        start = 1'b1; limit = 3'd2; reload_mode = 1'b1;
        expect_out("ign.run4", 4, 1, 0, 0);
        tick();
        start = 1'b0;
        expect_out("ign.run5", 5, 1, 0, 0);
        tick();
        expect_out("ign.done", 5, 0, 1, 1);
        tick();
        expect_out("ign.idle", 0, 0, 0, 0);
        tick();

        // Auto-reload, limit=7: two full wraps then abort
        launch(7, 1'b1, "ar7.start");
        for (int unsigned lap = 0; lap < 2; lap++) begin
            for (int unsigned i = 1; i <= 7; i++) begin
                expect_out("ar7.run", i, 1, 0, 0);
                tick();
            end
            expect_out("ar7.wrap", 0, 1, 0, 1);
            tick();
        end
        expect_out("ar7.run1", 1, 1, 0, 0);
        tick();
        abort = 1'b1;
        expect_out("ar7.abort", 0, 0, 0, 0);
        tick();
        abort = 1'b0;
        expect_out("ar7.idle", 0, 0, 0, 0);
        tick();

        // Pause at count 2 for three edges, limit=6 one-shot
        launch(6, 1'b0, "pz.start");
        for (int unsigned i = 1; i <= 2; i++) begin
            expect_out("pz.run", i, 1, 0, 0);
            tick();
        end
        pause = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            expect_out("pz.hold", 2, 1, 0, 0);
            tick();
        end
        pause = 1'b0;
        expect_out("pz.resume", 2, 1, 0, 0);
        tick();
        for (int unsigned i = 3; i <= 6; i++) begin
            expect_out("pz.run", i, 1, 0, 0);
            tick();
        end
        expect_out("pz.done", 6, 0, 1, 1);
        tick();
        expect_out("pz.idle", 0, 0, 0, 0);
        tick();

        // limit=0 one-shot
        launch(0, 1'b0, "z1.start");
        expect_out("z1.done", 0, 0, 1, 1);
        tick();
        expect_out("z1.idle", 0, 0, 0, 0);
        tick();

        // limit=0 auto-reload: tc every cycle
        launch(0, 1'b1, "z0.start");
        for (int unsigned i = 0; i < 3; i++) begin
            expect_out("z0.tc", 0, 1, 0, 1);
            tick();
        end
        abort = 1'b1;
        expect_out("z0.abort", 0, 0, 0, 0);
        tick();
        abort = 1'b0;

        // start+abort in IDLE: no run
        start = 1'b1; abort = 1'b1; limit = 3'd4;
        expect_out("sa.idle", 0, 0, 0, 0);
        tick();
        start = 1'b0; abort = 1'b0;
        expect_out("sa.idle2", 0, 0, 0, 0);
        tick();

        // pause on the terminal edge defers the terminal action
        launch(2, 1'b0, "pt.start");
        for (int unsigned i = 1; i <= 2; i++) begin
            expect_out("pt.run", i, 1, 0, 0);
            tick();
        end
        pause = 1'b1;
        expect_out("pt.hold", 2, 1, 0, 0);
        tick();
        pause = 1'b0;
        expect_out("pt.resume", 2, 1, 0, 0);
        tick();
        expect_out("pt.done", 2, 0, 1, 1);
        tick();
        expect_out("pt.idle", 0, 0, 0, 0);
        tick();

        // pause+abort in RUN -> IDLE
        launch(6, 1'b0, "pa.start");
        pause = 1'b1; abort = 1'b1;
        expect_out("pa.idle", 0, 0, 0, 0);
        tick();
        pause = 1'b0; abort = 1'b0;

        // Asynchronous reset mid-cycle at count 4
        launch(6, 1'b0, "ar.start");
        for (int unsigned i = 1; i <= 4; i++) begin
            expect_out("ar.run", i, 1, 0, 0);
            tick();
        end
        #3;
        reset = 1'b0;
        #1;
        check_eq("async.count", count, 0);
        check_eq("async.busy",  busy,  0);
        check_eq("async.done",  done,  0);
        check_eq("async.tc",    tc,    0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            expect_out("ar.idle", 0, 0, 0, 0);
            tick();
        end

        check_eq("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
